// File: rtl/alu_seq.sv
// Accumulator ALU with registered {Z,N,C,V} flags and a shift-add multiplier.
// Define ALU_SAT_EN to make add/sub saturate. States: IDLE | single-cycle ops accepted; RUN | multiply in progress.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             add,
  input  logic             sub,
  input  logic             mul,
  input  logic             land,
  input  logic             lor,
  input  logic             lnot,
  input  logic             shl,
  input  logic             shr,
  input  logic             write,
  input  logic             read,
  inout  wire  [WIDTH-1:0] Dbus,
  output logic [WIDTH-1:0] Acc,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res;
  logic               res_c, res_v;
  logic [2*WIDTH-1:0] prod_step;

  assign Dbus  = read ? acc_q : 'z;
  assign Acc   = acc_q;
  assign flags = flags_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, Dbus};
    diff  = {1'b0, acc_q} - {1'b0, Dbus};
    res   = Dbus;
    res_c = 1'b0;
    res_v = 1'b0;
    // Priority below mul: sub > add > land > lor > lnot > shl > shr > load
    if (sub) begin
      res_c = diff[WIDTH];
      res_v = (acc_q[WIDTH-1] != Dbus[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);
`ifdef ALU_SAT_EN
      res   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
      res   = diff[WIDTH-1:0];
`endif
    end else if (add) begin
      res_c = sum[WIDTH];
      res_v = (acc_q[WIDTH-1] == Dbus[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
`ifdef ALU_SAT_EN
      res   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
      res   = sum[WIDTH-1:0];
`endif
    end else if (land) begin
      res = acc_q & Dbus;
    end else if (lor) begin
      res = acc_q | Dbus;
    end else if (lnot) begin
      res = ~acc_q;
    end else if (shl) begin
      res   = {acc_q[WIDTH-2:0], 1'b0};
      res_c = acc_q[WIDTH-1];
    end else if (shr) begin
      res   = {1'b0, acc_q[WIDTH-1:1]};
      res_c = acc_q[0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      IDLE: begin
        if (write) begin
          if (mul) begin
            state_d  = RUN;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = Dbus;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            acc_d   = res;
            flags_d = {(res == '0), res[WIDTH-1], res_c, res_v};
          end
        end
      end
      RUN: begin
        // Write strobes are deliberately ignored here; nothing is queued.
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        prod_d   = prod_step;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = IDLE;
          acc_d   = prod_step[WIDTH-1:0];
          flags_d = {(prod_step[WIDTH-1:0] == '0), prod_step[WIDTH-1], 1'b0,
                     (prod_step[2*WIDTH-1:WIDTH] != '0)};
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops plus multiply/reset sequences.
module tb_alu_seq;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h04;
  localparam logic [7:0] OP_LAND = 8'h08;
  localparam logic [7:0] OP_LOR  = 8'h10;
  localparam logic [7:0] OP_LNOT = 8'h20;
  localparam logic [7:0] OP_SHL  = 8'h40;
  localparam logic [7:0] OP_SHR  = 8'h80;

`ifdef ALU_SAT_EN
  localparam logic [7:0] SUB_NEG_ACC = 8'h00; localparam logic [3:0] SUB_NEG_FLG = 4'b1010;
  localparam logic [7:0] ADD_OVF_ACC = 8'hFF; localparam logic [3:0] ADD_OVF_FLG = 4'b0110;
  localparam logic [7:0] ADD_WRP_ACC = 8'hFF; localparam logic [3:0] ADD_WRP_FLG = 4'b0110;
`else
  localparam logic [7:0] SUB_NEG_ACC = 8'hFB; localparam logic [3:0] SUB_NEG_FLG = 4'b0110;
  localparam logic [7:0] ADD_OVF_ACC = 8'h2C; localparam logic [3:0] ADD_OVF_FLG = 4'b0010;
  localparam logic [7:0] ADD_WRP_ACC = 8'h00; localparam logic [3:0] ADD_WRP_FLG = 4'b1010;
`endif

  typedef struct {
    logic [7:0] ops;
    logic       wr;
    logic [7:0] din;
    logic [7:0] acc;
    logic [3:0] flg;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [7:0] ops = 8'h00;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_bus = 8'h00;
  wire  [7:0] Dbus;
  logic [7:0] Acc;
  logic [3:0] flags;
  logic       busy, done;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  assign Dbus = tb_drv ? tb_bus : 8'bz;

  alu_seq #(.WIDTH(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .add(ops[0]), .sub(ops[1]), .mul(ops[2]), .land(ops[3]),
    .lor(ops[4]), .lnot(ops[5]), .shl(ops[6]), .shr(ops[7]),
    .write(write), .read(read), .Dbus(Dbus),
    .Acc(Acc), .flags(flags), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [7:0] o, input logic w, input logic [7:0] d,
                         input logic [7:0] a, input logic [3:0] f);
    vec_t v;
    v.ops = o; v.wr = w; v.din = d; v.acc = a; v.flg = f;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [7:0] o, input logic w, input logic [7:0] d);
    ops = o; write = w; tb_bus = d; tb_drv = 1'b1;
    @(posedge CLK); #1;
    ops = 8'h00; write = 1'b0; tb_drv = 1'b0;
  endtask

  // Loads a, starts a multiply by b, then watches busy/done until commit.
  task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_acc, input logic [3:0] exp_flg,
                         input bit intrude);
    int busy_cyc;
    int guard;
    step(8'h00, 1'b1, a);
    step(OP_MUL, 1'b1, b);
    chk({name, " busy after accept"}, 32'(busy), 32'd1);
    busy_cyc = 1;
    guard = 0;
    while (busy && guard < 20) begin
      if (intrude && busy_cyc == 3) begin
        step(OP_ADD, 1'b1, 8'hAA);
        chk({name, " acc held during busy"}, 32'(Acc), 32'(a));
        read = 1'b1; #1;
        chk({name, " read during busy"}, 32'(Dbus), 32'(a));
        read = 1'b0;
      end else begin
        @(posedge CLK); #1;
      end
      guard++;
      if (busy) busy_cyc++;
    end
    chk({name, " busy cycles"}, busy_cyc, 8);
    chk({name, " done at commit"}, 32'(done), 32'd1);
    chk({name, " acc"}, 32'(Acc), 32'(exp_acc));
    chk({name, " flags"}, 32'(flags), 32'(exp_flg));
  endtask

  initial begin
    int done_seen;

    // Initial reset
    repeat (3) @(posedge CLK);
    #1;
    chk("reset acc", 32'(Acc), 0);
    chk("reset flags", 32'(flags), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    nRST = 1'b1;
    step(8'h00, 1'b1, 8'h99);
    chk("pre-reset load", 32'(Acc), 32'h99);
    #2 nRST = 1'b0;
    #1;
    chk("async reset acc", 32'(Acc), 0);
    chk("async reset flags", 32'(flags), 0);
    @(posedge CLK); #1 nRST = 1'b1;

    add_vec(8'h00,  1, 8'd5,   8'd5,        4'b0000);
    add_vec(OP_ADD, 1, 8'd10,  8'd15,       4'b0000);
    add_vec(OP_SUB, 1, 8'd20,  SUB_NEG_ACC, SUB_NEG_FLG);
    add_vec(8'h00,  1, 8'd200, 8'd200,      4'b0100);
    add_vec(OP_ADD, 1, 8'd100, ADD_OVF_ACC, ADD_OVF_FLG);
    add_vec(8'h00,  1, 8'd3,   8'd3,        4'b0000);
    add_vec(OP_SUB, 1, 8'd3,   8'd0,        4'b1000);
    add_vec(8'h00,  1, 8'h81,  8'h81,       4'b0100);
    add_vec(OP_SHL, 1, 8'h00,  8'h02,       4'b0010);
    add_vec(OP_SHR, 1, 8'h00,  8'h01,       4'b0000);
    add_vec(OP_LAND,1, 8'h0F,  8'h01,       4'b0000);
    add_vec(OP_LNOT,1, 8'h33,  8'hFE,       4'b0100);
    add_vec(OP_LOR, 1, 8'h01,  8'hFF,       4'b0100);
    add_vec(OP_ADD, 1, 8'h01,  ADD_WRP_ACC, ADD_WRP_FLG);
    add_vec(OP_ADD, 0, 8'h55,  ADD_WRP_ACC, ADD_WRP_FLG);
    add_vec(8'h00,  1, 8'h7F,  8'h7F,       4'b0000);
    add_vec(OP_ADD, 1, 8'h01,  8'h80,       4'b0101);
    add_vec(OP_SUB, 1, 8'h01,  8'h7F,       4'b0001);
    add_vec(OP_SUB|OP_ADD|OP_LAND, 1, 8'h0F, 8'h70, 4'b0000);
    add_vec(OP_LAND|OP_LOR|OP_SHL|OP_SHR, 1, 8'h0F, 8'h00, 4'b1000);
    add_vec(8'h00,  1, 8'h41,  8'h41,       4'b0000);
    add_vec(OP_SHL|OP_SHR, 1, 8'h00, 8'h82, 4'b0100);
    add_vec(OP_LNOT|OP_SHL, 1, 8'h00, 8'h7D, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].ops, vecs[i].wr, vecs[i].din);
      chk($sformatf("vec%0d acc", i), 32'(Acc), 32'(vecs[i].acc));
      chk($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].flg));
      if (i == 0) begin
        read = 1'b1; #1;
        chk("read drives acc", 32'(Dbus), 32'd5);
        read = 1'b0;
      end
    end

    run_mul("mul 13x11", 8'd13, 8'd11, 8'd143, 4'b0100, 1'b0);
    @(posedge CLK); #1;
    chk("mul 13x11 done single", 32'(done), 0);

    run_mul("mul 20x20", 8'd20, 8'd20, 8'h90, 4'b0101, 1'b0);
    step(8'h00, 1'b1, 8'h33);
    chk("back-to-back load", 32'(Acc), 32'h33);

    run_mul("mul intrude", 8'd13, 8'd11, 8'd143, 4'b0100, 1'b1);

    step(8'h00, 1'b1, 8'd13);
    step(OP_MUL, 1'b1, 8'd11);
    repeat (4) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 0);
    chk("abort acc", 32'(Acc), 0);
    @(posedge CLK); #1 nRST = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (done) done_seen++;
    end
    chk("abort no done", done_seen, 0);
    chk("abort acc stays", 32'(Acc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the accumulator ALU of the Machine-class CPU; sits on the shared bidirectional data bus (Dbus) next to memory and the instruction decoder.
- Holds the accumulator and a registered flag set; executes single-cycle arithmetic, logic and shift ops on write strobes.
- Adds a multi-cycle shift-add unsigned multiplier with busy/done handshake.

Parameters:
- WIDTH, 8, data/accumulator width in bits (>=4).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- add  in  1  op select: Acc + Dbus.
- sub  in  1  op select: Acc - Dbus.
- mul  in  1  op select: Acc * Dbus (multi-cycle).
- land  in  1  op select: Acc & Dbus.
- lor  in  1  op select: Acc | Dbus.
- lnot  in  1  op select: ~Acc (Dbus ignored).
- shl  in  1  op select: Acc << 1.
- shr  in  1  op select: Acc >> 1 (logical).
- write  in  1  commit strobe, sampled on CLK rising edge.
- read  in  1  drive Acc onto Dbus.
- Dbus  inout  WIDTH  shared data bus.
- Acc  out  WIDTH  accumulator.
- flags  out  4  {Z,N,C,V}, registered.
- busy  out  1  multiplier running.
- done  out  1  one-cycle pulse when mul result commits.

Behaviour:
- Reset (async, nRST=0): Acc=0, flags=0, busy=0, done=0, multiplier state cleared. Reset mid-multiply aborts it; no result commits.
- Dbus driven with Acc whenever read=1 (combinational), else high-Z. During busy, read drives the pre-multiply Acc.
- Op decode priority when several selects are high: mul > sub > add > land > lor > lnot > shl > shr. No select high: plain load, Acc <= Dbus.
- Single-cycle ops: rising edge with write=1 and busy=0 commits result to Acc and flags on that edge.
- Flags: Z = (result==0); N = result[WIDTH-1]; update on every commit.
  - add: C = carry out; V = signed overflow.
  - sub: C = borrow (Acc < Dbus unsigned); V = signed overflow.
  - shl: C = old Acc[WIDTH-1]; shr: C = old Acc[0]; V=0.
  - land/lor/lnot/load: C=0, V=0.
- Multiply FSM, states IDLE, RUN:
  - IDLE + write + mul: capture Acc and Dbus into internal operand regs, counter=0, busy=1 from this edge, go RUN.
  - RUN: one shift-add step per cycle; counter increments.
  - After WIDTH RUN cycles (edge WIDTH after acceptance): Acc <= low WIDTH bits of 2*WIDTH product; Z,N from low half; C=0; V=1 iff high half nonzero; busy=0; done=1 for that cycle; go IDLE.
  - write while busy=1 is ignored entirely, whatever the op lines; no queueing.
  - done and a new accepted write may coincide on the cycle after commit (back-to-back legal).
- All arithmetic unsigned modulo 2^WIDTH unless ALU_SAT_EN applies.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: add clamps to all-ones on carry; sub clamps to 0 on borrow. C still reports the carry/borrow; V is computed from the unclamped result.
- Not defined: add/sub wrap modulo 2^WIDTH.
- Other ops are identical either way.

Test Plan (WIDTH=8):
- Reset then load: assert nRST=0 mid-run, then Dbus=5 with write, no op -> Acc=5, flags=0000. read=1 -> Dbus reads 5.
- Add/sub: Acc=5; add with Dbus=10 -> Acc=15. Then sub with Dbus=20 -> Acc=0xFB, C=1, N=1, Z=0.
- Overflow/saturation: Acc=200; add with Dbus=100 -> Acc=44, C=1 without ALU_SAT_EN; Acc=255, C=1 with it. Acc=3; sub 3 -> Acc=0, Z=1.
- Shifts/logic: Acc=0x81; shl -> 0x02, C=1. shr -> 0x01, C=0. land with 0x0F -> 0x01. lnot -> 0xFE, N=1.
- Multiply: Acc=13; mul with 11 -> busy=1 for exactly 8 cycles, then Acc=143, V=0, done pulses once. Acc=20; mul with 20 -> Acc=0x90, V=1, N=1.
- Busy/reset corner: write+add during busy -> ignored, final product unchanged. nRST=0 at RUN cycle 4 -> busy=0, Acc=0, no done pulse.
